// File: rtl/rv32_pkg.sv
// Shared RV32 execute-stage types: ALU/branch/md opcodes, pipeline registers, md helpers.
package rv32_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
        ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
    } alu_op_e;

    typedef enum logic [3:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
    } br_op_e;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

    localparam int          DIV_ITERS  = 32;
    localparam logic [31:0] DIV_ZERO_Q = '1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        br_op_e      br_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_pipeline_reg_t;

    // Same layout as id_ex_pipeline_reg_t plus the md controls at the tail.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        alu_src_imm;
        br_op_e      br_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        md_en;
        md_op_e      md_op;
    } id_ex_md_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_pipeline_reg_t;

    function automatic logic md_is_div(md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic md_is_sdiv(md_op_e op);
        return op inside {MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/alu.sv
// Base single-cycle integer ALU.
module alu
    import rv32_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] result_o
);
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:   result_o = a_i + b_i;
            ALU_SUB:   result_o = a_i - b_i;
            ALU_AND:   result_o = a_i & b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_SLL:   result_o = a_i << b_i[4:0];
            ALU_SRL:   result_o = a_i >> b_i[4:0];
            ALU_SRA:   result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_SLT:   result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:  result_o = {31'b0, a_i < b_i};
            ALU_PASSB: result_o = b_i;
            default:   result_o = '0;
        endcase
    end
endmodule

// File: rtl/branch_unit.sv
// Base branch/jump resolution: condition evaluation and target computation.
module branch_unit
    import rv32_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] imm_i,
    input  br_op_e      op_i,
    output logic        taken_o,
    output logic [31:0] target_o
);
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_EQ:           taken_o = (a_i == b_i);
            BR_NE:           taken_o = (a_i != b_i);
            BR_LT:           taken_o = ($signed(a_i) <  $signed(b_i));
            BR_GE:           taken_o = ($signed(a_i) >= $signed(b_i));
            BR_LTU:          taken_o = (a_i <  b_i);
            BR_GEU:          taken_o = (a_i >= b_i);
            BR_JAL, BR_JALR: taken_o = 1'b1;
            default:         taken_o = 1'b0;
        endcase
        target_o = (op_i == BR_JALR) ? ((a_i + imm_i) & ~32'd1) : (pc_i + imm_i);
    end
endmodule

// File: rtl/ex_stage_md_md_unit.sv
// RV32M multiply/divide engine: launch latches, multi-cycle multiplier, restoring divider.
module md_unit
    import rv32_pkg::*;
#(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        kill_i,
    input  logic        hold_i,
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);
    md_state_e   state_q;
    md_op_e      op_q;
    logic [5:0]  cnt_q;
    logic [31:0] op_a_q, op_b_q, quo_q, rem_q, quo_d, rem_d;
    logic [31:0] abs_a_i, abs_b, q_fix, r_fix;
    logic [32:0] trial, diff;
    logic [63:0] ma, mb, prod;
    logic        sdiv_i, sdiv, b_zero, ovf, special_i;

    assign sdiv_i    = md_is_sdiv(op_i);
    assign abs_a_i   = (sdiv_i && a_i[31]) ? -a_i : a_i;
    assign special_i = (b_i == '0) || (sdiv_i && a_i == 32'h8000_0000 && b_i == '1);

    assign sdiv   = md_is_sdiv(op_q);
    assign abs_b  = (sdiv && op_b_q[31]) ? -op_b_q : op_b_q;
    assign b_zero = (op_b_q == '0);
    assign ovf    = sdiv && op_a_q == 32'h8000_0000 && op_b_q == '1;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, abs_b};
    assign rem_d = diff[32] ? trial[31:0] : diff[31:0];
    assign quo_d = {quo_q[30:0], ~diff[32]};

    assign q_fix = (sdiv && (op_a_q[31] ^ op_b_q[31])) ? -quo_q : quo_q;
    assign r_fix = (sdiv && op_a_q[31]) ? -rem_q : rem_q;

    assign ma   = {{32{(op_q == MD_MULH || op_q == MD_MULHSU) && op_a_q[31]}}, op_a_q};
    assign mb   = {{32{(op_q == MD_MULH) && op_b_q[31]}}, op_b_q};
    assign prod = ma * mb;

    always_comb begin
        result_o = prod[31:0];
        case (op_q)
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[63:32];
            MD_DIV, MD_DIVU: result_o = b_zero ? DIV_ZERO_Q : (ovf ? 32'h8000_0000 : q_fix);
            MD_REM, MD_REMU: result_o = b_zero ? op_a_q : (ovf ? 32'h0 : r_fix);
            default:         result_o = prod[31:0];
        endcase
    end

    assign busy_o = (state_q == S_MUL) || (state_q == S_DIV);
    assign done_o = (state_q == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= MD_MUL;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    op_q   <= op_i;
                    op_a_q <= a_i;
                    op_b_q <= b_i;
                    quo_q  <= abs_a_i;
                    rem_q  <= '0;
                    if (md_is_div(op_i)) begin
                        state_q <= S_DIV;
                        cnt_q   <= special_i ? 6'd1 : 6'(DIV_ITERS);
                    end else if (MUL_STAGES == 1) begin
                        state_q <= S_DONE;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_MUL;
                        cnt_q   <= 6'(MUL_STAGES - 1);
                    end
                end
                S_MUL: begin
                    cnt_q <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) state_q <= S_DONE;
                end
                S_DIV: begin
                    cnt_q <= cnt_q - 6'd1;
                    quo_q <= quo_d;
                    rem_q <= rem_d;
                    if (cnt_q == 6'd1) state_q <= S_DONE;
                end
                S_DONE:  if (!hold_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: forwarding muxes, ALU, branch resolution and the multi-cycle md unit.
module ex_stage_md
    import rv32_pkg::*;
#(
    parameter int NUM_FWD    = 2,
    parameter int MUL_STAGES = 2,
    parameter int DIV_EN     = 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  id_ex_md_reg_t                    id_ex_i,
    input  logic [$clog2(NUM_FWD+1)-1:0]     fwd_sel_a_i,
    input  logic [$clog2(NUM_FWD+1)-1:0]     fwd_sel_b_i,
    input  logic [NUM_FWD-1:0][31:0]         fwd_data_i,
    input  logic                             mem_ready_i,
    input  logic                             flush_i,
    output logic                             stall_o,
    output logic [31:0]                      branch_target_o,
    output logic                             branch_taken_o,
    output ex_mem_pipeline_reg_t             ex_mem_o
);
    logic [31:0] op_a, op_b, alu_b, alu_res, md_res;
    logic        br_taken, md_busy, md_done, md_go, launch;
    ex_mem_pipeline_reg_t ex_mem_d, ex_mem_q;

    always_comb begin
        op_a = id_ex_i.rs1_data;
        op_b = id_ex_i.rs2_data;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (int'(fwd_sel_a_i) == k) op_a = fwd_data_i[k-1];
            if (int'(fwd_sel_b_i) == k) op_b = fwd_data_i[k-1];
        end
    end

    assign alu_b = id_ex_i.alu_src_imm ? id_ex_i.imm : op_b;

    alu u_alu (.a_i(op_a), .b_i(alu_b), .op_i(id_ex_i.alu_op), .result_o(alu_res));

    branch_unit u_br (
        .pc_i(id_ex_i.pc), .a_i(op_a), .b_i(op_b), .imm_i(id_ex_i.imm),
        .op_i(id_ex_i.br_op), .taken_o(br_taken), .target_o(branch_target_o)
    );

    // Without a divider, divides take the single-cycle path and return 0.
    assign md_go  = id_ex_i.valid & id_ex_i.md_en & ((DIV_EN != 0) | !md_is_div(id_ex_i.md_op));
    assign launch = md_go & mem_ready_i & !flush_i & !md_busy & !md_done;

    md_unit #(.MUL_STAGES(MUL_STAGES)) u_md (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(launch), .kill_i(flush_i),
        .hold_i(!mem_ready_i), .op_i(id_ex_i.md_op), .a_i(op_a), .b_i(op_b),
        .busy_o(md_busy), .done_o(md_done), .result_o(md_res)
    );

    assign stall_o        = !rst_i & !flush_i & (md_busy | launch | !mem_ready_i);
    assign branch_taken_o = br_taken & !stall_o & !flush_i & !rst_i & id_ex_i.valid;

    always_comb begin
        ex_mem_d = ex_mem_q;
        if (flush_i) begin
            ex_mem_d = '0;
        end else if (mem_ready_i) begin
            if (md_busy || launch) begin
                ex_mem_d = '0;
            end else begin
                ex_mem_d.valid      = id_ex_i.valid;
                ex_mem_d.pc         = id_ex_i.pc;
                ex_mem_d.rs2_data   = op_b;
                ex_mem_d.rd         = id_ex_i.rd;
                ex_mem_d.reg_write  = id_ex_i.reg_write;
                ex_mem_d.mem_read   = id_ex_i.mem_read;
                ex_mem_d.mem_write  = id_ex_i.mem_write;
                ex_mem_d.alu_result = md_done ? md_res : (id_ex_i.md_en ? 32'h0 : alu_res);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ex_mem_q <= '0;
        else       ex_mem_q <= ex_mem_d;
    end

    assign ex_mem_o = ex_mem_q;
endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: results are queued at issue and popped when MEM accepts.
module tb_ex_stage_md;
    import rv32_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, mem_ready, flush, stall, br_taken;
    logic [31:0]          br_target;
    logic [1:0]           sel_a, sel_b;
    logic [1:0][31:0]     fwd_data;
    id_ex_md_reg_t        id_ex;
    ex_mem_pipeline_reg_t ex_mem;
    int                   n_chk = 0, n_pass = 0;
    logic [31:0]          sb_q[$];
    logic [31:0]          exp_v;

    always #5 clk = ~clk;

    ex_stage_md #(.NUM_FWD(2), .MUL_STAGES(2), .DIV_EN(1)) dut (
        .clk_i(clk), .rst_i(rst), .id_ex_i(id_ex), .fwd_sel_a_i(sel_a), .fwd_sel_b_i(sel_b),
        .fwd_data_i(fwd_data), .mem_ready_i(mem_ready), .flush_i(flush), .stall_o(stall),
        .branch_target_o(br_target), .branch_taken_o(br_taken), .ex_mem_o(ex_mem)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic id_ex_md_reg_t mk(input alu_op_e aop, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic md,
                                         input md_op_e mop, input br_op_e bop);
        id_ex_md_reg_t t;
        t           = '0;
        t.valid     = 1'b1;
        t.pc        = 32'h100;
        t.rs1_data  = r1;
        t.rs2_data  = r2;
        t.imm       = 32'h20;
        t.rd        = 5'd3;
        t.alu_op    = aop;
        t.br_op     = bop;
        t.reg_write = 1'b1;
        t.md_en     = md;
        t.md_op     = mop;
        return t;
    endfunction

    // MEM consumes ex_mem_o in any cycle where it is valid and mem_ready_i is high.
    always @(negedge clk) begin
        if (!rst && mem_ready && ex_mem.valid === 1'b1) begin
            chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                chk("result", ex_mem.alu_result, exp_v);
            end
        end
    end

    task automatic run_md(input string tag, input md_op_e mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int nstall);
        id_ex = mk(ALU_ADD, a, b, 1'b1, mop, BR_NONE);
        sel_a = 2'd0;
        sel_b = 2'd0;
        sb_q.push_back(exp);
        for (int i = 0; i < nstall; i++) begin
            #1 chk({tag, "_stall"}, 32'(stall), 32'd1);
            if (i > 0) chk({tag, "_bubble"}, 32'(ex_mem.valid), 32'd0);
            tick();
        end
        #1 chk({tag, "_done_stall"}, 32'(stall), 32'd0);
        tick();
        id_ex = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        sel_a = 2'd0; sel_b = 2'd0; fwd_data = '0;
        id_ex = mk(ALU_ADD, 32'd9, 32'd9, 1'b0, MD_MUL, BR_EQ);
        #1 chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_br_taken", 32'(br_taken), 32'd0);
        tick(); tick();
        chk("rst_valid", 32'(ex_mem.valid), 32'd0);
        chk("rst_result", ex_mem.alu_result, 32'd0);
        rst = 1'b0; mem_ready = 1'b1; id_ex = '0;
        tick();

        // ADD with operand a forwarded from the older source.
        id_ex = mk(ALU_ADD, 32'd100, 32'd7, 1'b0, MD_MUL, BR_NONE);
        sel_a = 2'd2; fwd_data[1] = 32'd5; fwd_data[0] = 32'd1000;
        sb_q.push_back(32'd12);
        #1 chk("add_stall", 32'(stall), 32'd0);
        tick();
        chk("add_valid", 32'(ex_mem.valid), 32'd1);

        // Out-of-range select falls back to rs1; b from the youngest source.
        id_ex = mk(ALU_SUB, 32'd100, 32'd7, 1'b0, MD_MUL, BR_NONE);
        sel_a = 2'd3; sel_b = 2'd1;
        sb_q.push_back(32'hFFFF_FC7C);
        #1 chk("sub_stall", 32'(stall), 32'd0);
        tick();
        chk("fwd_rs2", ex_mem.rs2_data, 32'd1000);

        run_md("mulh",   MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2);
        run_md("mul",    MD_MUL,    32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFF4, 2);
        run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_md("mulhu",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        run_md("div",    MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_md("rem",    MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_md("divu0",  MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run_md("rem0",   MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2);
        run_md("divovf", MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_md("removf", MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run_md("remu",   MD_REMU,   32'd100,       32'd7,         32'd2,         33);
        run_md("divu",   MD_DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 33);

        // Flush mid-divide: no result, no stall, next ADD flows normally.
        id_ex = mk(ALU_ADD, 32'd100, 32'd3, 1'b1, MD_DIV, BR_NONE);
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1 chk("flush_stall", 32'(stall), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_bubble", 32'(ex_mem.valid), 32'd0);
        id_ex = mk(ALU_ADD, 32'd3, 32'd4, 1'b0, MD_MUL, BR_NONE);
        sb_q.push_back(32'd7);
        #1 chk("post_flush_stall", 32'(stall), 32'd0);
        tick();
        chk("post_flush_valid", 32'(ex_mem.valid), 32'd1);
        id_ex = '0;

        // MEM backpressure while in DONE, then on the delivered result.
        id_ex = mk(ALU_ADD, 32'd6, 32'd7, 1'b1, MD_MUL, BR_NONE);
        sb_q.push_back(32'd42);
        tick(); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("done_hold_stall", 32'(stall), 32'd1);
            chk("done_hold_bubble", 32'(ex_mem.valid), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1 chk("done_release_stall", 32'(stall), 32'd0);
        tick();
        id_ex = '0;
        mem_ready = 1'b0;
        #1 chk("held_result", ex_mem.alu_result, 32'd42);
        tick();
        chk("held_result2", ex_mem.alu_result, 32'd42);
        chk("held_valid", 32'(ex_mem.valid), 32'd1);

        // BEQ: suppressed under stall, taken once MEM is ready, suppressed by flush.
        id_ex = mk(ALU_ADD, 32'd9, 32'd9, 1'b0, MD_MUL, BR_EQ);
        sel_a = 2'd0; sel_b = 2'd0;
        #1 chk("beq_stalled_taken", 32'(br_taken), 32'd0);
        chk("beq_stalled_stall", 32'(stall), 32'd1);
        tick();
        mem_ready = 1'b1;
        sb_q.push_back(32'd18);
        #1 chk("beq_taken", 32'(br_taken), 32'd1);
        chk("beq_target", br_target, 32'h120);
        tick();
        id_ex = mk(ALU_ADD, 32'd1, 32'd2, 1'b0, MD_MUL, BR_NE);
        flush = 1'b1;
        #1 chk("bne_flush_taken", 32'(br_taken), 32'd0);
        tick();
        flush = 1'b0;
        id_ex = '0;

        repeat (4) tick();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
